// File: rtl/lsu_issue_queue_ord_if.sv
// Bundle of every non-clock signal of the LSU issue queue: the allocation side
// from the router, wakeup broadcasts, the PRF read port and the issue packet
// handed to fu_lsu. The queue itself connects through the slave modport.
interface lsu_issue_queue_ord_if #(
   parameter int DEPTH        = 8,
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int FU_COUNT     = 4
);
   localparam int OCC_BITS = $clog2(DEPTH + 1);

   logic                                                  inst_valid;
   logic                                                  inst_is_store;
   logic                                                  queue_ready;
   logic [INST_ID_BITS-1:0]                               inst_id;
   logic [31:0]                                           raw_instr;
   logic [63:0]                                           instr_pc;
   logic [MAX_OPERANDS-1:0]                               prn_input_valid;
   logic [MAX_OPERANDS-1:0]                               prn_input_ready;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 prn_input;
   logic [MAX_OPERANDS-1:0]                               prn_output_valid;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 prn_output;
   logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                 set_prn_ready;
   logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   set_prn;
   logic                                                  flush;
   logic [MAX_OPERANDS-1:0]                               prf_read_enable;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 prf_read_prn;
   logic [MAX_OPERANDS-1:0][63:0]                         prf_op;
   logic                                                  iss_valid;
   logic                                                  iss_ready;
   logic [INST_ID_BITS-1:0]                               iss_inst_id;
   logic [31:0]                                           iss_raw_instr;
   logic [63:0]                                           iss_pc;
   logic [MAX_OPERANDS-1:0][63:0]                         iss_op;
   logic [MAX_OPERANDS-1:0]                               iss_op_valid;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                 iss_prn_out;
   logic [MAX_OPERANDS-1:0]                               iss_prn_out_valid;
   logic [OCC_BITS-1:0]                                   occupancy;

   modport master (
      output inst_valid, inst_is_store, inst_id, raw_instr, instr_pc,
             prn_input_valid, prn_input_ready, prn_input, prn_output_valid, prn_output,
             set_prn_ready, set_prn, flush, prf_op, iss_ready,
      input  queue_ready, prf_read_enable, prf_read_prn, iss_valid, iss_inst_id,
             iss_raw_instr, iss_pc, iss_op, iss_op_valid, iss_prn_out,
             iss_prn_out_valid, occupancy
   );

   modport slave (
      input  inst_valid, inst_is_store, inst_id, raw_instr, instr_pc,
             prn_input_valid, prn_input_ready, prn_input, prn_output_valid, prn_output,
             set_prn_ready, set_prn, flush, prf_op, iss_ready,
      output queue_ready, prf_read_enable, prf_read_prn, iss_valid, iss_inst_id,
             iss_raw_instr, iss_pc, iss_op, iss_op_valid, iss_prn_out,
             iss_prn_out_valid, occupancy
   );
endinterface

// File: rtl/lsu_issue_queue_ord.sv
// Compacting LSU issue queue. Index 0 always holds the oldest instruction;
// removing an entry slides every younger entry down one slot on the same edge.
// The oldest ready entry (subject to store ordering when ORDERED=1) reads the
// PRF combinationally and lands in a registered issue packet for fu_lsu.
module lsu_issue_queue_ord #(
   parameter int DEPTH        = 8,
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int FU_COUNT     = 4,
   parameter bit ORDERED      = 1'b1
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   lsu_issue_queue_ord_if.slave bus
);
   localparam int OCC_BITS = $clog2(DEPTH + 1);
   localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic                                  isStore;
      logic [INST_ID_BITS-1:0]               id;
      logic [31:0]                           raw;
      logic [63:0]                           pc;
      logic [MAX_OPERANDS-1:0]               srcValid;
      logic [MAX_OPERANDS-1:0]               srcRdy;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] srcPrn;
      logic [MAX_OPERANDS-1:0]               dstValid;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dstPrn;
   } entry_t;

   entry_t                                entry_q [DEPTH];
   entry_t                                entry_d [DEPTH];
   entry_t                                woken   [DEPTH+1];
   entry_t                                newEntry;
   entry_t                                selEntry;
   logic [OCC_BITS-1:0]                   occ_q;
   logic [OCC_BITS-1:0]                   occ_d;
   logic [OCC_BITS-1:0]                   wrIdx;
   logic [DEPTH-1:0]                      eligible;
   logic                                  storeSeen;
   logic                                  doIssue;
   logic                                  advance;
   logic                                  alloc;
   logic [IDX_BITS-1:0]                   selIdx;

   logic                                  issValid_q;
   logic [INST_ID_BITS-1:0]               issId_q;
   logic [31:0]                           issRaw_q;
   logic [63:0]                           issPc_q;
   logic [MAX_OPERANDS-1:0][63:0]         issOp_q;
   logic [MAX_OPERANDS-1:0]               issOpValid_q;
   logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] issPrnOut_q;
   logic [MAX_OPERANDS-1:0]               issPrnOutValid_q;

   // True when any wakeup port strobes the given PRN this cycle.
   function automatic logic wakeHit(
      input logic [PRN_BITS-1:0]                             prn,
      input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               strobe,
      input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] prns
   );
      logic hit;
      hit = 1'b0;
      for (int f = 0; f < FU_COUNT; f++) begin
         for (int o = 0; o < MAX_OPERANDS; o++) begin
            if (strobe[f][o] && (prns[f][o] == prn)) hit = 1'b1;
         end
      end
      return hit;
   endfunction

   assign bus.queue_ready = (occ_q < OCC_BITS'(DEPTH));
   assign bus.occupancy   = occ_q;
   assign advance         = !issValid_q || bus.iss_ready;
   assign alloc           = bus.inst_valid && bus.queue_ready;
   assign selEntry        = entry_q[selIdx];

   // Work out which entries may issue, then pick the oldest of them when the
   // issue register is free to take a new packet.
   always_comb begin
      eligible  = '0;
      storeSeen = 1'b0;
      doIssue   = 1'b0;
      selIdx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (OCC_BITS'(i) < occ_q) begin
            if (&(~entry_q[i].srcValid | entry_q[i].srcRdy)) begin
               if (!ORDERED)                eligible[i] = 1'b1;
               else if (entry_q[i].isStore) eligible[i] = (i == 0);
               else                         eligible[i] = !storeSeen;
            end
            if (entry_q[i].isStore) storeSeen = 1'b1;
         end
      end
      if (advance) begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
               doIssue = 1'b1;
               selIdx  = IDX_BITS'(i);
            end
         end
      end
   end

   // Drive the PRF read port for the selected entry's used source slots only.
   always_comb begin
      bus.prf_read_enable = '0;
      bus.prf_read_prn    = '0;
      if (doIssue) begin
         bus.prf_read_enable = selEntry.srcValid;
         for (int k = 0; k < MAX_OPERANDS; k++) begin
            if (selEntry.srcValid[k]) bus.prf_read_prn[k] = selEntry.srcPrn[k];
         end
      end
   end

   // Next queue contents: apply wakeups, compact over the issued slot, then
   // append the new instruction behind the surviving entries.
   always_comb begin
      newEntry          = '0;
      newEntry.isStore  = bus.inst_is_store;
      newEntry.id       = bus.inst_id;
      newEntry.raw      = bus.raw_instr;
      newEntry.pc       = bus.instr_pc;
      newEntry.srcValid = bus.prn_input_valid;
      newEntry.srcPrn   = bus.prn_input;
      newEntry.dstValid = bus.prn_output_valid;
      newEntry.dstPrn   = bus.prn_output;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         newEntry.srcRdy[k] = !bus.prn_input_valid[k] || bus.prn_input_ready[k] ||
                              wakeHit(bus.prn_input[k], bus.set_prn_ready, bus.set_prn);
      end
      for (int i = 0; i < DEPTH; i++) begin
         woken[i] = entry_q[i];
         for (int k = 0; k < MAX_OPERANDS; k++) begin
            if (wakeHit(entry_q[i].srcPrn[k], bus.set_prn_ready, bus.set_prn)) begin
               woken[i].srcRdy[k] = 1'b1;
            end
         end
      end
      woken[DEPTH] = '0;
      wrIdx = occ_q - OCC_BITS'(doIssue);
      occ_d = occ_q + OCC_BITS'(alloc) - OCC_BITS'(doIssue);
      for (int i = 0; i < DEPTH; i++) begin
         entry_d[i] = woken[i];
         if (doIssue && (IDX_BITS'(i) >= selIdx)) entry_d[i] = woken[i+1];
         if (alloc && (OCC_BITS'(i) == wrIdx)) entry_d[i] = newEntry;
      end
   end

   // State update; flush wipes the queue and the pending packet ahead of
   // any allocation or issue in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         occ_q            <= '0;
         issValid_q       <= 1'b0;
         issId_q          <= '0;
         issRaw_q         <= '0;
         issPc_q          <= '0;
         issOp_q          <= '0;
         issOpValid_q     <= '0;
         issPrnOut_q      <= '0;
         issPrnOutValid_q <= '0;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      end else if (bus.flush) begin
         occ_q      <= '0;
         issValid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      end else begin
         occ_q <= occ_d;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
         if (doIssue) begin
            issValid_q       <= 1'b1;
            issId_q          <= selEntry.id;
            issRaw_q         <= selEntry.raw;
            issPc_q          <= selEntry.pc;
            issOp_q          <= bus.prf_op;
            issOpValid_q     <= selEntry.srcValid;
            issPrnOut_q      <= selEntry.dstPrn;
            issPrnOutValid_q <= selEntry.dstValid;
         end else if (bus.iss_ready) begin
            issValid_q <= 1'b0;
         end
      end
   end

   assign bus.iss_valid         = issValid_q;
   assign bus.iss_inst_id       = issId_q;
   assign bus.iss_raw_instr     = issRaw_q;
   assign bus.iss_pc            = issPc_q;
   assign bus.iss_op            = issOp_q;
   assign bus.iss_op_valid      = issOpValid_q;
   assign bus.iss_prn_out       = issPrnOut_q;
   assign bus.iss_prn_out_valid = issPrnOutValid_q;
endmodule

// File: doc/lsu_issue_queue_ord.md
Name: lsu_issue_queue_ord

Overview:
Parametrised load/store issue queue, successor to the single-FU LSU queue wrapper. Holds up to DEPTH LSU instructions and wakes operands from FU_COUNT broadcast ports. Selects the oldest ready entry under a configurable memory-ordering rule, reads the PRF, and presents a registered issue packet to fu_lsu over a valid/ready handshake. Sits between the instruction router and fu_lsu.

Parameters:
DEPTH, 8, queue entries (>=2)
INST_ID_BITS, 6, instruction id width
PRN_BITS, 6, physical register number width
MAX_OPERANDS, 3, source/destination slots per instruction
FU_COUNT, 4, wakeup broadcast ports (including this LSU's own writeback)
ORDERED, 1, 1 = enforce store ordering; 0 = pure oldest-ready select

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
inst_valid  in  1  allocate request
inst_is_store  in  1  incoming instruction is a store
queue_ready  out  1  space available (count < DEPTH)
inst_id  in  INST_ID_BITS  incoming id
raw_instr  in  32  incoming encoding
instr_pc  in  64  incoming PC
prn_input_valid[MAX_OPERANDS]  in  1  source slot used
prn_input_ready[MAX_OPERANDS]  in  1  source already available at allocation
prn_input[MAX_OPERANDS]  in  PRN_BITS  source PRNs
prn_output_valid[MAX_OPERANDS]  in  1  destination slot used
prn_output[MAX_OPERANDS]  in  PRN_BITS  destination PRNs
set_prn_ready[FU_COUNT][MAX_OPERANDS]  in  1  wakeup strobe
set_prn[FU_COUNT][MAX_OPERANDS]  in  PRN_BITS  wakeup PRN
flush  in  1  synchronous clear of all entries and the issue register
prf_read_enable[MAX_OPERANDS]  out  1  PRF read strobe
prf_read_prn[MAX_OPERANDS]  out  PRN_BITS  PRF read address
prf_op[MAX_OPERANDS]  in  64  PRF read data, same cycle (combinational PRF)
iss_valid  out  1  issue packet valid
iss_ready  in  1  fu_lsu accepts packet
iss_inst_id  out  INST_ID_BITS
iss_raw_instr  out  32
iss_pc  out  64
iss_op[MAX_OPERANDS]  out  64  operand data
iss_op_valid[MAX_OPERANDS]  out  1
iss_prn_out[MAX_OPERANDS]  out  PRN_BITS
iss_prn_out_valid[MAX_OPERANDS]  out  1
occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Reset (rst=0, async):
  - All entries invalid; occupancy=0; queue_ready=1.
  - iss_valid=0; all iss_* data, prf_read_enable and prf_read_prn zero.
  - Reset mid-operation discards everything.
- Storage is a compacting queue. Index 0 is oldest. On removal, younger entries shift down one slot in the same edge.
- Allocation: fires on inst_valid && queue_ready at an edge. The entry is written at index occupancy (post-removal index if an issue occurs in the same cycle). queue_ready uses only registered occupancy, so simultaneous alloc and issue at DEPTH-1 are both legal. inst_valid while !queue_ready is ignored.
- Source ready bit at allocation = !prn_input_valid | prn_input_ready | (any wakeup port matching this cycle).
- Wakeup: each valid, not-ready source compares against all FU_COUNT*MAX_OPERANDS strobed PRNs and sets ready at the edge. An entry woken in cycle T is selectable in T+1 at the earliest.
- Eligible entry: valid and all sources ready.
  - ORDERED=1: a load is eligible only if no older entry is a store. A store is eligible only if it is index 0.
  - ORDERED=0: no ordering constraint.
- Select: lowest-index eligible entry, evaluated only when advance = !iss_valid || iss_ready.
- Issue:
  - In selection cycle T, prf_read_enable/prf_read_prn are driven for the selected entry's valid sources; otherwise prf_read_enable=0.
  - At the T edge, the issue register captures the entry fields, prf_op into iss_op, and the slot valids; the entry is removed. iss_valid=1 from T+1.
  - iss_valid && !iss_ready holds all iss_* stable; no selection occurs.
  - Back-to-back issue: 1 per cycle while iss_ready=1.
- Flush: at the edge, clears all entries and iss_valid. Allocation in the same cycle is dropped. Flush has priority over all other updates.
- occupancy next = occupancy + alloc - issue; never exceeds DEPTH or drops below 0.

Test Plan:
- Reset, allocate id=5 (load, sources ready) with iss_ready=1 -> prf_read_enable asserted cycle 1, iss_valid=1 cycle 2 with iss_inst_id=5 and iss_op equal to prf_op; occupancy returns to 0.
- Allocate 8 instructions with a not-ready source (PRN 12) -> queue_ready=0 at occupancy 8; 9th inst_valid ignored; strobe set_prn[1][0]=12 -> all eight issue in age order over 8 consecutive cycles.
- ORDERED=1: store A (src PRN 3 not ready) then ready load B -> B is held; wake PRN 3 -> A issues, then B the following cycle. With ORDERED=0, B issues first.
- Hold iss_ready=0 for 3 cycles with iss_valid=1 -> iss_* unchanged and occupancy unchanged; release -> next entry issues the following cycle.
- Allocate with prn_input_ready=0 while the same PRN is strobed on set_prn the same cycle -> the entry is selectable the next cycle.
- flush asserted together with inst_valid at occupancy 4, and separately rst pulsed low mid-issue -> occupancy=0, iss_valid=0, queue_ready=1 after the edge (flush) or immediately (rst).
